// File: rtl/usr_shift_core.sv
// Register stage of a universal shift register: runs one of eight operations for a
// programmed number of steps under a valid/ready handshake. Optional: USR_PARITY_EN adds a registered parity output.
module usr_shift_core #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_pdata,
    input  logic             cmd_sr_in,
    input  logic             cmd_sl_in,
    output logic [WIDTH-1:0] q,
    output logic             so_right,
    output logic             so_left,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {
        M_HOLD, M_SHR, M_SHL, M_LOAD, M_ROR, M_ROL, M_ASR, M_CLR
    } mode_t;

    state_t             state_q, state_d;
    mode_t              mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   pdata_q;
    logic               sr_in_q, sl_in_q;
    logic [WIDTH-1:0]   q_step;
    logic               sor_step, sol_step;
    logic               accept;

    assign accept = cmd_valid && cmd_ready;

    // Next value of the register for one step of the captured operation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        q_step   = q;
        sor_step = so_right;
        sol_step = so_left;
        unique case (mode_q)
            M_HOLD: q_step = q;
            M_SHR: begin
                q_step   = {sr_in_q, q[WIDTH-1:1]};
                sor_step = q[0];
            end
            M_SHL: begin
                q_step   = {q[WIDTH-2:0], sl_in_q};
                sol_step = q[WIDTH-1];
            end
            M_LOAD: q_step = pdata_q;
            M_ROR: begin
                q_step   = {q[0], q[WIDTH-1:1]};
                sor_step = q[0];
            end
            M_ROL: begin
                q_step   = {q[WIDTH-2:0], q[WIDTH-1]};
                sol_step = q[WIDTH-1];
            end
            M_ASR: begin
                q_step   = {q[WIDTH-1], q[WIDTH-1:1]};
                sor_step = q[0];
            end
            M_CLR: q_step = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = (cmd_count == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= M_HOLD;
            cnt_q    <= '0;
            pdata_q  <= '0;
            sr_in_q  <= 1'b0;
            sl_in_q  <= 1'b0;
            q        <= '0;
            so_right <= 1'b0;
            so_left  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q  <= mode_t'(cmd_mode);
                cnt_q   <= cmd_count;
                pdata_q <= cmd_pdata;
                sr_in_q <= cmd_sr_in;
                sl_in_q <= cmd_sl_in;
            end
            if (state_q == S_RUN) begin
                q        <= q_step;
                so_right <= sor_step;
                so_left  <= sol_step;
                cnt_q    <= cnt_q - 1'b1;
            end
        end
    end

`ifdef USR_PARITY_EN
    // Parity tracks q on the same edge rather than being derived from it afterwards.
    always_ff @(posedge clk) begin
        if (rst)
            parity <= 1'b0;
        else if (state_q == S_RUN)
            parity <= ^q_step;
    end
`endif

endmodule

// File: tb/tb_usr_shift_core.sv
// Self-checking bench for usr_shift_core: directed scenarios plus random commands
// compared cycle by cycle against an arithmetic reference model.
module tb_usr_shift_core;

    localparam int W   = 8;
    localparam int CNT = 4;
`ifdef USR_PARITY_EN
    localparam int VW = W + 6;
`else
    localparam int VW = W + 5;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd_mode = '0;
    logic [CNT-1:0] cmd_count = '0;
    logic [W-1:0]   cmd_pdata = '0;
    logic           cmd_sr_in = 1'b0;
    logic           cmd_sl_in = 1'b0;
    logic [W-1:0]   q;
    logic           so_right, so_left, busy, done;
`ifdef USR_PARITY_EN
    logic           parity;
`endif

    usr_shift_core #(.WIDTH(W), .CNT_W(CNT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_count(cmd_count), .cmd_pdata(cmd_pdata),
        .cmd_sr_in(cmd_sr_in), .cmd_sl_in(cmd_sl_in),
        .q(q), .so_right(so_right), .so_left(so_left),
        .busy(busy), .done(done)
`ifdef USR_PARITY_EN
        , .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [W-1:0] m_q;
    logic         m_sr, m_sl;

    function automatic void model_reset();
        m_q  = '0;
        m_sr = 1'b0;
        m_sl = 1'b0;
    endfunction

    // One step computed with plain integer arithmetic.
    function automatic void model_step(input logic [2:0] m, input logic [W-1:0] pd,
                                       input logic si, input logic li);
        int v;
        int top;
        v   = int'(m_q);
        top = 1 << (W - 1);
        case (m)
            3'd1: begin m_sr = m_q[0];   v = v / 2 + (si ? top : 0); end
            3'd2: begin m_sl = m_q[W-1]; v = (v * 2) % (2 * top) + int'(li); end
            3'd3: v = int'(pd);
            3'd4: begin m_sr = m_q[0];   v = v / 2 + (v % 2) * top; end
            3'd5: begin m_sl = m_q[W-1]; v = (v * 2) % (2 * top) + v / top; end
            3'd6: begin m_sr = m_q[0];   v = v / 2 + (v / top) * top; end
            3'd7: v = 0;
            default: ;
        endcase
        m_q = W'(v);
    endfunction

    function automatic logic [VW-1:0] observed();
`ifdef USR_PARITY_EN
        return {q, so_right, so_left, busy, done, cmd_ready, parity};
`else
        return {q, so_right, so_left, busy, done, cmd_ready};
`endif
    endfunction

    function automatic logic [VW-1:0] expected(input logic b, input logic d, input logic r);
`ifdef USR_PARITY_EN
        return {m_q, m_sr, m_sl, b, d, r, ^m_q};
`else
        return {m_q, m_sr, m_sl, b, d, r};
`endif
    endfunction

    // Issue one command and check every cycle until the block is idle again.
    task automatic run_cmd(input logic [2:0] m, input logic [CNT-1:0] n, input logic [W-1:0] pd,
                           input logic si, input logic li, input logic keep_valid, input string tag);
        int waited = 0;
        logic [VW-1:0] obs, exp;
        while (!cmd_ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL %s: cmd_ready=%b after %0d cycles, required 1", tag, cmd_ready, waited);
            return;
        end
        cmd_valid = 1'b1; cmd_mode = m; cmd_count = n;
        cmd_pdata = pd; cmd_sr_in = si; cmd_sl_in = li;
        @(posedge clk); #1;
        if (!keep_valid) cmd_valid = 1'b0;
        cmd_mode  = 3'($urandom);
        cmd_count = CNT'($urandom);
        cmd_pdata = W'($urandom);
        cmd_sr_in = 1'($urandom);
        cmd_sl_in = 1'($urandom);
        for (int k = 1; k <= int'(n); k++) begin
            obs = observed(); exp = expected(1'b1, 1'b0, 1'b0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s run step %0d: got %h, required %h", tag, k, obs, exp);
            end
            model_step(m, pd, si, li);
            @(posedge clk); #1;
        end
        obs = observed(); exp = expected(1'b0, 1'b1, 1'b0);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s done cycle: got %h, required %h", tag, obs, exp);
        end
        @(posedge clk); #1;
        obs = observed(); exp = expected(1'b0, 1'b0, 1'b1);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s idle after done: got %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic test_reset();
        logic [VW-1:0] obs, exp;
        rst = 1'b1; cmd_valid = 1'b1; cmd_count = 4'd3; cmd_mode = 3'd3; cmd_pdata = 8'hFF;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            obs = observed(); exp = expected(1'b0, 1'b0, 1'b1);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %h, required %h", i, obs, exp);
            end
        end
        cmd_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_load();
        run_cmd(3'd3, 4'd1, 8'hA5, 1'b0, 1'b0, 1'b0, "load_a5");
    endtask

    task automatic test_shr();
        run_cmd(3'd1, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0, "shr_x3");
        vectors++;
        if (q !== 8'hF4) begin
            miscompares++;
            $display("FAIL shr_result: q=%h, required f4", q);
        end
    endtask

    task automatic test_rol_asr();
        run_cmd(3'd3, 4'd1, 8'h81, 1'b0, 1'b0, 1'b0, "load_81");
        run_cmd(3'd5, 4'd9, 8'h00, 1'b0, 1'b0, 1'b0, "rol_x9");
        vectors++;
        if (q !== 8'h03) begin
            miscompares++;
            $display("FAIL rol_result: q=%h, required 03", q);
        end
        run_cmd(3'd3, 4'd1, 8'h80, 1'b0, 1'b0, 1'b0, "load_80");
        run_cmd(3'd6, 4'd7, 8'h00, 1'b0, 1'b0, 1'b0, "asr_x7");
        vectors++;
        if (q !== 8'hFF) begin
            miscompares++;
            $display("FAIL asr_result: q=%h, required ff", q);
        end
    endtask

    task automatic test_count_zero();
        run_cmd(3'd3, 4'd1, 8'h3C, 1'b0, 1'b0, 1'b0, "load_3c");
        for (int m = 0; m < 8; m++)
            run_cmd(3'(m), 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, "count_zero");
    endtask

    task automatic test_abort();
        logic [VW-1:0] obs, exp;
        run_cmd(3'd3, 4'd1, 8'h5A, 1'b0, 1'b0, 1'b0, "load_5a");
        cmd_valid = 1'b1; cmd_mode = 3'd2; cmd_count = 4'd5; cmd_sl_in = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            model_step(3'd2, 8'h00, 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        obs = observed(); exp = expected(1'b1, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL abort pre-reset: got %h, required %h", obs, exp);
        end
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            obs = observed(); exp = expected(1'b0, 1'b0, 1'b1);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL abort idle %0d: got %h, required %h", i, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // cmd_valid stays high through RUN/DONE; the next accept must wait for IDLE.
    task automatic test_back_to_back();
        run_cmd(3'd4, 4'd2, 8'h00, 1'b0, 1'b0, 1'b1, "b2b_first");
        run_cmd(3'd2, 4'd3, 8'h00, 1'b0, 1'b1, 1'b1, "b2b_second");
        run_cmd(3'd3, 4'd1, 8'hC3, 1'b0, 1'b0, 1'b0, "b2b_third");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            run_cmd(3'($urandom), CNT'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 1)), "random");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_shr();
        test_rol_asr();
        test_count_zero();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
